// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART front-end:
// register offsets, control/error bit positions and load size encodings.
package mmio_uart_pkg;

  localparam logic [4:0] REG_TX_STAT = 5'h00;
  localparam logic [4:0] REG_RX_STAT = 5'h04;
  localparam logic [4:0] REG_TX_DATA = 5'h08;
  localparam logic [4:0] REG_RX_DATA = 5'h0C;
  localparam logic [4:0] REG_COUNT   = 5'h10;
  localparam logic [4:0] REG_IRQ_EN  = 5'h14;
  localparam logic [4:0] REG_ERR     = 5'h18;
  localparam logic [4:0] REG_RSVD    = 5'h1C;

  localparam int CTRL_RX_IRQ   = 0;
  localparam int CTRL_TX_IRQ   = 1;
  localparam int CTRL_LOOPBACK = 2;

  localparam int ERR_RX_OVF = 0;
  localparam int ERR_TX_OVF = 1;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b11
  } mem_size_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with power-of-two depth and occupancy count.
// A push into a full FIFO is only accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; only entries between the pointers are ever observed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mmio_uart_fifo.sv
// Memory-mapped UART front-end with buffered RX/TX, status, IRQ enables and sticky errors.
// Define MMIO_UART_LOOPBACK_EN to build the internal TX->RX loopback (control bit2).
module mmio_uart_fifo
  import mmio_uart_pkg::*;
#(
  parameter int          RX_DEPTH  = 16,
  parameter int          TX_DEPTH  = 16,
  parameter int          RX_THRESH = 1,
  parameter logic [31:0] IO_BASE   = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] address,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic [31:0] write_data,
  input  logic [1:0]  mem_size,
  input  logic        load_unsigned,
  output logic [31:0] result,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready,
  output logic        irq_rx,
  output logic        irq_tx
);

  localparam int RX_CW = $clog2(RX_DEPTH) + 1;
  localparam int TX_CW = $clog2(TX_DEPTH) + 1;

  logic             hit;
  logic [4:0]       offset;
  logic             acc_rd;
  logic             acc_wr;

  logic             rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]       rx_din, rx_dout;
  logic [RX_CW-1:0] rx_count;
  logic             tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]       tx_dout;
  logic [TX_CW-1:0] tx_count;

  logic [2:0]       ctrl_q, ctrl_d;
  logic [1:0]       err_q, err_d;
  logic             irq_rx_q, irq_tx_q;
  logic             rx_ovf_set, tx_ovf_set;
  logic [31:0]      rdata;
  logic             unused_bits;

  assign hit    = (address[31:5] == IO_BASE[31:5]);
  assign offset = {address[4:2], 2'b00};
  assign acc_rd = read_enable & ~stall & hit;
  assign acc_wr = write_enable & ~stall & hit;

  assign rx_pop  = acc_rd & (offset == REG_RX_DATA);
  assign tx_push = acc_wr & (offset == REG_TX_DATA);

`ifdef MMIO_UART_LOOPBACK_EN
  localparam logic [2:0] CTRL_MASK = 3'b111;
  logic lb_pop;

  // In loopback the TX head moves straight into RX whenever RX has room this cycle.
  assign lb_pop        = ctrl_q[CTRL_LOOPBACK] & ~tx_empty & (~rx_full | rx_pop);
  assign tx_pop        = ctrl_q[CTRL_LOOPBACK] ? lb_pop : (~tx_empty & uart_tx_ready);
  assign rx_push       = ctrl_q[CTRL_LOOPBACK] ? lb_pop : uart_rx_valid;
  assign rx_din        = ctrl_q[CTRL_LOOPBACK] ? tx_dout : uart_rx_data;
  assign uart_tx_valid = ~tx_empty & ~ctrl_q[CTRL_LOOPBACK];
`else
  localparam logic [2:0] CTRL_MASK = 3'b011;

  assign tx_pop        = ~tx_empty & uart_tx_ready;
  assign rx_push       = uart_rx_valid;
  assign rx_din        = uart_rx_data;
  assign uart_tx_valid = ~tx_empty;
`endif

  assign uart_tx_data  = tx_dout;
  assign uart_rx_ready = 1'b1;

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (rx_din),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (write_data[7:0]),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  // A full FIFO still accepts a push if it is drained in the same cycle.
  assign rx_ovf_set = rx_push & rx_full & ~rx_pop;
  assign tx_ovf_set = tx_push & tx_full & ~tx_pop;

  // Set events are applied after the W1C so a coincident overflow is never lost.
  always_comb begin
    ctrl_d = ctrl_q;
    err_d  = err_q;
    if (acc_wr && (offset == REG_IRQ_EN)) ctrl_d = write_data[2:0] & CTRL_MASK;
    if (acc_wr && (offset == REG_ERR))    err_d  = err_q & ~write_data[1:0];
    if (rx_ovf_set) err_d[ERR_RX_OVF] = 1'b1;
    if (tx_ovf_set) err_d[ERR_TX_OVF] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q   <= '0;
      err_q    <= '0;
      irq_rx_q <= 1'b0;
      irq_tx_q <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      err_q    <= err_d;
      irq_rx_q <= ctrl_q[CTRL_RX_IRQ] & (rx_count >= RX_CW'(RX_THRESH));
      irq_tx_q <= ctrl_q[CTRL_TX_IRQ] & tx_empty;
    end
  end

  assign irq_rx = irq_rx_q;
  assign irq_tx = irq_tx_q;

  always_comb begin
    rdata = '0;
    if (acc_rd) begin
      case (offset)
        REG_TX_STAT: rdata[0] = ~tx_full;
        REG_RX_STAT: rdata[0] = ~rx_empty;
        REG_RX_DATA: begin
          if (!rx_empty) begin
            if ((mem_size == SIZE_BYTE) && !load_unsigned) rdata = {{24{rx_dout[7]}}, rx_dout};
            else                                           rdata = {24'h0, rx_dout};
          end
        end
        REG_COUNT:   rdata = {16'(tx_count), 16'(rx_count)};
        REG_IRQ_EN:  rdata = {29'h0, ctrl_q};
        REG_ERR:     rdata = {30'h0, err_q};
        default:     rdata = '0;
      endcase
    end
  end

  assign result = rdata;

  assign unused_bits = ^{address[1:0], write_data[31:8]};

endmodule

// File: tb/tb_mmio_uart_fifo.sv
// Self-checking bench for mmio_uart_fifo: scoreboard queues model RX/TX byte order,
// register reads are compared against bench-derived values.
module tb_mmio_uart_fifo;

  localparam int          RX_DEPTH = 16;
  localparam int          TX_DEPTH = 16;
  localparam logic [31:0] BASE     = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [31:0] address;
  logic        read_enable;
  logic        write_enable;
  logic [31:0] write_data;
  logic [1:0]  mem_size;
  logic        load_unsigned;
  logic [31:0] result;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_ready;
  logic        irq_rx;
  logic        irq_tx;

  int assertCount = 0;
  int failCount   = 0;

  logic [7:0] rxQ[$];
  logic [7:0] txQ[$];

  mmio_uart_fifo #(
    .RX_DEPTH (RX_DEPTH),
    .TX_DEPTH (TX_DEPTH),
    .RX_THRESH(1),
    .IO_BASE  (BASE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .address      (address),
    .read_enable  (read_enable),
    .write_enable (write_enable),
    .write_data   (write_data),
    .mem_size     (mem_size),
    .load_unsigned(load_unsigned),
    .result       (result),
    .uart_tx_data (uart_tx_data),
    .uart_tx_valid(uart_tx_valid),
    .uart_tx_ready(uart_tx_ready),
    .uart_rx_data (uart_rx_data),
    .uart_rx_valid(uart_rx_valid),
    .uart_rx_ready(uart_rx_ready),
    .irq_rx       (irq_rx),
    .irq_tx       (irq_tx)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpuRead(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                         output logic [31:0] data);
    address       = addr;
    mem_size      = size;
    load_unsigned = uns;
    read_enable   = 1'b1;
    #1;
    data = result;
    tick();
    read_enable = 1'b0;
    address     = 32'h0;
  endtask

  task automatic cpuWrite(input logic [31:0] addr, input logic [31:0] data);
    address      = addr;
    write_data   = data;
    mem_size     = 2'b11;
    write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
    address      = 32'h0;
  endtask

  task automatic checkReg(input string tag, input logic [4:0] off, input logic [31:0] expected);
    logic [31:0] d;
    cpuRead(BASE + 32'(off), 2'b11, 1'b0, d);
    checkOutput(tag, d, expected);
  endtask

  // Drive one received byte; the model keeps it only if the RX FIFO has room.
  task automatic applyStimulus(input logic [7:0] b);
    uart_rx_valid = 1'b1;
    uart_rx_data  = b;
    if (rxQ.size() < RX_DEPTH) rxQ.push_back(b);
    tick();
    uart_rx_valid = 1'b0;
  endtask

  function automatic logic [31:0] expRx(input logic [7:0] b, input logic [1:0] size, input logic uns);
    if (size == 2'b00 && !uns) return {{24{b[7]}}, b};
    return {24'h0, b};
  endfunction

  task automatic readRxCheck(input string tag, input logic [1:0] size, input logic uns);
    logic [31:0] d;
    logic [31:0] exp;
    if (rxQ.size() == 0) exp = 32'h0;
    else                 exp = expRx(rxQ.pop_front(), size, uns);
    cpuRead(BASE + 32'h0C, size, uns, d);
    checkOutput(tag, d, exp);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] d;
    logic [31:0] exp;
    logic        found;

    rst = 1'b1; stall = 1'b0; address = 32'h0; read_enable = 1'b0; write_enable = 1'b0;
    write_data = 32'h0; mem_size = 2'b11; load_unsigned = 1'b0; uart_tx_ready = 1'b0;
    uart_rx_data = 8'hEE; uart_rx_valid = 1'b1;
    repeat (3) tick();
    checkOutput("rx_ready_in_reset", 32'(uart_rx_ready), 32'h1);
    rst = 1'b0;
    uart_rx_valid = 1'b0;

    // Reset state; bytes offered during reset must have been discarded
    checkOutput("irq_rx_reset", 32'(irq_rx), 32'h0);
    checkOutput("irq_tx_reset", 32'(irq_tx), 32'h0);
    checkOutput("tx_valid_reset", 32'(uart_tx_valid), 32'h0);
    checkOutput("rx_ready", 32'(uart_rx_ready), 32'h1);
    checkReg("tx_stat_reset", 5'h00, 32'h1);
    checkReg("rx_stat_reset", 5'h04, 32'h0);
    checkReg("count_reset", 5'h10, 32'h0);
    checkReg("irq_en_reset", 5'h14, 32'h0);
    checkReg("err_reset", 5'h18, 32'h0);
    checkReg("reserved", 5'h1C, 32'h0);
    cpuRead(32'h9000_0000, 2'b11, 1'b0, d);
    checkOutput("out_of_window", d, 32'h0);

    // TX path with transmitter back-pressured
    cpuWrite(BASE + 32'h08, 32'h41); txQ.push_back(8'h41);
    cpuWrite(BASE + 32'h08, 32'h42); txQ.push_back(8'h42);
    checkReg("tx_count_2", 5'h10, 32'h0002_0000);
    checkOutput("tx_valid_2", 32'(uart_tx_valid), 32'h1);
    checkOutput("tx_head_0", 32'(uart_tx_data), 32'(txQ[0]));
    uart_tx_ready = 1'b1;
    tick(); void'(txQ.pop_front());
    checkOutput("tx_head_1", 32'(uart_tx_data), 32'(txQ[0]));
    tick(); void'(txQ.pop_front());
    uart_tx_ready = 1'b0;
    checkOutput("tx_valid_empty", 32'(uart_tx_valid), 32'h0);
    checkReg("tx_count_0", 5'h10, 32'h0);

    // TX interrupt: registered one cycle after the enable lands
    cpuWrite(BASE + 32'h14, 32'h2);
    checkOutput("irq_tx_latency", 32'(irq_tx), 32'h0);
    tick();
    checkOutput("irq_tx_set", 32'(irq_tx), 32'h1);
    cpuWrite(BASE + 32'h14, 32'h0);
    tick();
    checkOutput("irq_tx_clear", 32'(irq_tx), 32'h0);

    // RX overflow with 17 bytes into a 16-deep FIFO
    for (int i = 0; i < 17; i++) applyStimulus(8'h80 + 8'(i));
    checkReg("rx_count_full", 5'h10, 32'(RX_DEPTH));
    checkReg("rx_overflow", 5'h18, 32'h1);
    checkReg("rx_stat_full", 5'h04, 32'h1);
    uart_rx_valid = 1'b1; uart_rx_data = 8'h99;
    cpuWrite(BASE + 32'h18, 32'h1);
    uart_rx_valid = 1'b0;
    checkReg("err_set_wins", 5'h18, 32'h1);
    readRxCheck("lb_sext", 2'b00, 1'b0);
    readRxCheck("lbu_zext", 2'b00, 1'b1);
    cpuWrite(BASE + 32'h18, 32'h1);
    checkReg("err_w1c", 5'h18, 32'h0);

    // Stalled load of RX data: no pop until the stall drops, then exactly one
    address = BASE + 32'h0C; mem_size = 2'b11; load_unsigned = 1'b0;
    read_enable = 1'b1; stall = 1'b1;
    repeat (3) tick();
    stall = 1'b0;
    #1;
    d = result;
    exp = expRx(rxQ.pop_front(), 2'b11, 1'b0);
    tick();
    read_enable = 1'b0; address = 32'h0;
    checkOutput("stall_pop_data", d, exp);
    checkReg("stall_count", 5'h10, 32'(RX_DEPTH - 3));
    while (rxQ.size() > 0) readRxCheck("rx_drain", 2'b11, 1'b0);
    readRxCheck("rx_empty_read", 2'b11, 1'b0);
    checkReg("rx_stat_empty", 5'h04, 32'h0);

    // Push and pop together on an empty RX FIFO: pop ignored, push lands
    uart_rx_valid = 1'b1; uart_rx_data = 8'h33;
    cpuRead(BASE + 32'h0C, 2'b11, 1'b0, d);
    uart_rx_valid = 1'b0;
    rxQ.push_back(8'h33);
    checkOutput("empty_push_pop", d, 32'h0);
    checkReg("empty_push_count", 5'h10, 32'h1);
    readRxCheck("empty_push_data", 2'b11, 1'b0);

    // Push and pop together on a full RX FIFO: both succeed, no overflow
    for (int i = 0; i < RX_DEPTH; i++) applyStimulus(8'h10 + 8'(i));
    uart_rx_valid = 1'b1; uart_rx_data = 8'hAA;
    readRxCheck("full_push_pop", 2'b11, 1'b0);
    uart_rx_valid = 1'b0;
    rxQ.push_back(8'hAA);
    checkReg("full_push_count", 5'h10, 32'(RX_DEPTH));
    checkReg("full_push_noerr", 5'h18, 32'h0);
    while (rxQ.size() > 0) readRxCheck("rx_drain2", 2'b11, 1'b0);

    // RX interrupt timing with threshold 1
    cpuWrite(BASE + 32'h14, 32'h1);
    applyStimulus(8'h55);
    checkOutput("irq_rx_latency", 32'(irq_rx), 32'h0);
    tick();
    checkOutput("irq_rx_set", 32'(irq_rx), 32'h1);
    readRxCheck("irq_rx_pop", 2'b11, 1'b0);
    checkOutput("irq_rx_hold", 32'(irq_rx), 32'h1);
    tick();
    checkOutput("irq_rx_clear", 32'(irq_rx), 32'h0);
    cpuWrite(BASE + 32'h14, 32'h0);

    // TX overflow, then simultaneous push and pop on a full TX FIFO
    uart_tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      cpuWrite(BASE + 32'h08, 32'hC0 + 32'(i));
      if (txQ.size() < TX_DEPTH) txQ.push_back(8'hC0 + 8'(i));
    end
    checkReg("tx_stat_full", 5'h00, 32'h0);
    checkReg("tx_overflow", 5'h18, 32'h2);
    cpuWrite(BASE + 32'h18, 32'h2);
    checkReg("tx_err_w1c", 5'h18, 32'h0);
    uart_tx_ready = 1'b1;
    checkOutput("tx_full_head", 32'(uart_tx_data), 32'(txQ[0]));
    cpuWrite(BASE + 32'h08, 32'hEE);
    uart_tx_ready = 1'b0;
    void'(txQ.pop_front());
    txQ.push_back(8'hEE);
    checkReg("tx_full_push_count", 5'h10, 32'(TX_DEPTH) << 16);
    checkReg("tx_full_push_noerr", 5'h18, 32'h0);
    uart_tx_ready = 1'b1;
    for (int i = 0; i < 40 && txQ.size() > 0; i++) begin
      checkOutput("tx_drain_valid", 32'(uart_tx_valid), 32'h1);
      checkOutput("tx_drain_data", 32'(uart_tx_data), 32'(txQ.pop_front()));
      tick();
    end
    uart_tx_ready = 1'b0;
    checkOutput("tx_drained", 32'(uart_tx_valid), 32'h0);

`ifdef MMIO_UART_LOOPBACK_EN
    cpuWrite(BASE + 32'h14, 32'h4);
    checkReg("lb_ctrl", 5'h14, 32'h4);
    cpuWrite(BASE + 32'h08, 32'h5A);
    checkOutput("lb_tx_valid", 32'(uart_tx_valid), 32'h0);
    found = 1'b0;
    for (int i = 0; i < 2 && !found; i++) begin
      cpuRead(BASE + 32'h04, 2'b11, 1'b0, d);
      if (d[0]) found = 1'b1;
      checkOutput("lb_tx_valid_hold", 32'(uart_tx_valid), 32'h0);
    end
    checkOutput("lb_arrived", 32'(found), 32'h1);
    rxQ.push_back(8'h5A);
    readRxCheck("lb_data", 2'b11, 1'b0);
`else
    found = 1'b0;
    cpuWrite(BASE + 32'h14, 32'h4);
    checkReg("lb_ctrl_ignored", 5'h14, 32'(found));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mmio_uart_fifo.md
Name: mmio_uart_fifo

Overview:
- Memory-mapped UART front-end for the CPU's IO region (address[31:28] = 4'h8). It replaces the single-byte, unbuffered UART interface.
- Sits between the M-stage load/store signals and the UART core. Buffers received and transmitted bytes in parametrised FIFOs.
- Exposes status, count, interrupt-enable and sticky-error registers.
- Drives level interrupt requests to COP0.

Parameters:
- RX_DEPTH, 16, RX FIFO entries; power of 2, >= 2.
- TX_DEPTH, 16, TX FIFO entries; power of 2, >= 2.
- RX_THRESH, 1, RX occupancy at or above which irq_rx may assert; 1..RX_DEPTH.
- IO_BASE, 32'h8000_0000, base address of the register window; window is IO_BASE..IO_BASE+0x1C.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  pipeline stall; no register side effects while high
- address  in  32  M-stage byte address
- read_enable  in  1  M-stage load
- write_enable  in  1  M-stage store
- write_data  in  32  store data; only [7:0] used for TX data
- mem_size  in  2  00 byte, 01 half, 11 word
- load_unsigned  in  1  zero-extend byte loads
- result  out  32  combinational load data
- uart_tx_data  out  8  byte to UART transmitter (head of TX FIFO)
- uart_tx_valid  out  1  TX FIFO non-empty
- uart_tx_ready  in  1  transmitter accepts byte
- uart_rx_data  in  8  received byte
- uart_rx_valid  in  1  received byte available
- uart_rx_ready  out  1  constant 1; receiver never back-pressured
- irq_rx  out  1  RX interrupt request, level
- irq_tx  out  1  TX interrupt request, level

Behaviour:
- Register map (byte offsets from IO_BASE). Accesses outside the window: result = 0, no effect.
  - 0x00 R: bit0 = TX not full.
  - 0x04 R: bit0 = RX not empty.
  - 0x08 W: push write_data[7:0] to TX FIFO.
  - 0x0C R: pop RX FIFO.
  - 0x10 R: [15:0] rx_count, [31:16] tx_count.
  - 0x14 R/W: bit0 rx_irq_en, bit1 tx_irq_en, bit2 loopback (optional feature only).
  - 0x18 R/W1C: bit0 rx_overflow, bit1 tx_overflow.
  - 0x1C reserved, reads 0.
- Access qualifiers: acc_rd = read_enable & ~stall & hit; acc_wr = write_enable & ~stall & hit.
- Loads:
  - result is combinational from address and current state; zero latency, same cycle.
  - 0x0C when RX empty: result = 0, no pop, no error.
  - 0x0C byte load (mem_size 00) with load_unsigned = 0: sign-extend bit 7. All other loads: zero-extend.
- Pops and pushes take effect at the clk edge of the qualifying cycle. A stalled cycle never pops or pushes.
- RX FIFO:
  - Push when uart_rx_valid.
  - If full, and not popped in the same cycle: byte dropped, rx_overflow set.
  - Push and pop in the same cycle on a full FIFO: both succeed, count unchanged.
  - Push and pop in the same cycle on an empty FIFO: the pop is ignored (result = 0) and the push succeeds.
- TX FIFO:
  - uart_tx_valid = ~tx_empty; uart_tx_data = head.
  - Pop on uart_tx_valid & uart_tx_ready.
  - CPU push when full, unless popped the same cycle: dropped, tx_overflow set.
  - Simultaneous push and pop: count unchanged.
- Counts: width clog2(DEPTH)+1. Pointers wrap modulo DEPTH; full when count == DEPTH.
- Sticky flags: cleared only by writing 1 to 0x18. A set event in the same cycle as the clear wins.
- Interrupts (registered; update one cycle after the causing edge):
  - irq_rx = rx_irq_en & (rx_count >= RX_THRESH).
  - irq_tx = tx_irq_en & tx_empty.
- Reset:
  - FIFOs empty, counts 0, enables 0, flags 0, irq_rx = irq_tx = 0.
  - uart_tx_valid = 0; result = 0 unless a window read is active.
  - Reset mid-transfer discards all buffered bytes.
  - uart_rx_ready = 1 during and after reset; bytes arriving while rst is high are discarded.

Optional Feature:
- Macro: MMIO_UART_LOOPBACK_EN.
- Defined: control bit2 is writable. When set:
  - uart_tx_valid is held 0.
  - The TX head pops internally whenever the RX FIFO can accept it, and is pushed into RX. uart_rx_valid is ignored.
- Undefined: bit2 reads 0, writes ignored, no loopback logic is synthesised.

Decomposition:
- Package mmio_uart_pkg:
  - register offset constants (REG_TX_STAT, REG_RX_STAT, REG_TX_DATA, REG_RX_DATA, REG_COUNT, REG_IRQ_EN, REG_ERR);
  - control/error bit indices;
  - mem_size encodings.
- One sub-module, sync_fifo (params WIDTH, DEPTH; ports push, pop, din, dout, full, empty, count). Instantiated twice.

Test Plan:
- Reset, then read 0x00/0x04/0x10 -> 1 / 0 / 0; irq_rx = irq_tx = 0; uart_tx_valid = 0.
- Store 0x41, 0x42 to 0x08 with uart_tx_ready low.
  -> tx_count = 2, uart_tx_data = 0x41.
  - Raise ready for one cycle -> uart_tx_data = 0x42.
  - Next cycle -> FIFO empty.
- Inject 17 RX bytes 0x80..0x90 with RX_DEPTH = 16.
  -> rx_count = 16, 0x18 bit0 = 1.
  - lb from 0x0C -> 0xFFFFFF80; lbu next -> 0x00000081.
  - Write 1 to 0x18 -> reads 0.
- Assert stall with a load of 0x0C pending for 3 cycles -> no pop; after stall drops exactly one pop.
- Set rx_irq_en, RX_THRESH = 1, inject one byte -> irq_rx high the following cycle; pop it -> irq_rx low the cycle after.
- With MMIO_UART_LOOPBACK_EN, set bit2, store 0x5A -> uart_tx_valid stays 0; load 0x0C returns 0x5A within 2 cycles.
